rect_fill_engine: RTL and testbench
===================================

// Module: rect_fill_engine
// PURPOSE
//   Rasterises one filled-rectangle command per handshake into a stream of single-pixel writes.
//   The stream is one pixel per clock and drives the x/y/colour/plot inputs of the 160x120 VGA adapter.
//   The block sits between the draw controller (load X/Y/colour, clear keys) and the adapter.
//   It replaces ad-hoc square/clear counters with one clipped fill engine.
// PARAMETERS
//   SCREEN_W  160  visible width in pixels; x range 0..SCREEN_W-1
//   SCREEN_H  120  visible height in pixels; y range 0..SCREEN_H-1
//   XW        8    x coordinate / width field bits
//   YW        7    y coordinate / height field bits
//   CW        3    colour bits (RGB, 1 bit per channel)
// PORTS
//   clk         in   1   system clock (CLOCK_50)
//   reset       in   1   synchronous, active-low reset
//   cmd_valid   in   1   command present
//   cmd_ready   out  1   engine can accept a command (high only in IDLE)
//   cmd_clear   in   1   1 = clear screen; ignores cmd_x/y/w/h/colour
//   cmd_x       in   XW  top-left x
//   cmd_y       in   YW  top-left y
//   cmd_w       in   XW  width in pixels (0 = empty)
//   cmd_h       in   YW  height in pixels (0 = empty)
//   cmd_colour  in   CW  fill colour
//   pix_x       out  XW  pixel x to adapter
//   pix_y       out  YW  pixel y to adapter
//   pix_colour  out  CW  pixel colour to adapter
//   pix_plot    out  1   write strobe; one pixel per high cycle
//   busy        out  1   high from accept until done
//   done        out  1   one-cycle pulse when the command completes
// BEHAVIOUR
//   Reset is synchronous, active-low, on clk, and overrides everything:
//     - next edge: state=IDLE; pix_x/pix_y/pix_colour/pix_plot/busy/done=0.
//     - Any in-flight command is dropped; no further plots are issued.
//   Accept: cmd_valid & cmd_ready at a rising edge. The command is latched into internal registers.
//     - cmd_* inputs are don't-care afterwards.
//     - cmd_valid while busy is ignored (cmd_ready=0); it is never queued.
//   Clear command: latched as x=0, y=0, w=SCREEN_W, h=SCREEN_H, colour=0.
//   FSM states and transitions:
//     - IDLE -> SETUP on accept.
//     - SETUP -> FILL, or SETUP -> DONE if empty.
//     - FILL -> DONE after the last pixel.
//     - DONE -> IDLE unconditionally.
//   SETUP (1 cycle) clipping:
//     - Empty if x>=SCREEN_W, y>=SCREEN_H, w==0 or h==0.
//     - Otherwise x_last = min(x+w, SCREEN_W)-1 and y_last = min(y+h, SCREEN_H)-1.
//     - Sums are computed XW+1 / YW+1 bits wide; no wrap-around.
//   FILL, raster order:
//     - x is the inner loop, from x to x_last; y steps from y to y_last.
//     - pix_plot=1 with a valid pix_x/pix_y/pix_colour every FILL cycle; outputs are registered.
//     - Pixel count = (x_last-x+1)*(y_last-y+1); clear = 19200 pixels.
//   Timing:
//     - Accept at edge E0, SETUP during cycle E0..E1.
//     - First plot is visible after E1; last plot after E(N).
//     - done=1 and busy still 1 in the cycle after the last plot.
//     - cmd_ready=1 in the following cycle.
//   Empty command: no plots; done pulses 2 cycles after accept.
//   busy = (state != IDLE); pix_plot=0 outside FILL.
//   Outside FILL, pix_x/pix_y/pix_colour hold their last value.
// TESTING
//   1. Command: x=10, y=20, w=4, h=4, colour=3'b101.
//      -> 16 plots: (10,20),(11,20)..(13,23), all colour 101; done 1 cycle after (13,23).
//   2. Command: x=158, y=118, w=4, h=4.
//      -> exactly 4 plots: (158,118),(159,118),(158,119),(159,119); no x>=160 or y>=120.
//   3. cmd_clear=1.
//      -> 19200 consecutive plots, colour 0, first (0,0), last (159,119); busy high throughout.
//   4. w=0, or x=200.
//      -> zero plots; done pulses exactly 2 cycles after accept; cmd_ready back to 1.
//   5. reset=0 during the 5th pixel of test 1.
//      -> next edge pix_plot=0, busy=0, done=0; a new command is accepted right after reset release.
//   6. Second command held valid during test 1.
//      -> not accepted while busy; accepted the first IDLE cycle after done; both fills complete in order.

Source files
------------

// File: rtl/rect_fill_if.sv
// rect_fill_if: command handshake and pixel stream between draw controller, fill engine and VGA adapter
//   master: controller side (drives cmd_*, observes ready/pixel/status)
//   slave:  engine side (accepts cmd_*, drives cmd_ready, pix_*, busy, done)
interface rect_fill_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_clear;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [XW-1:0] cmd_w;
  logic [YW-1:0] cmd_h;
  logic [CW-1:0] cmd_colour;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_colour;
  logic          pix_plot;
  logic          busy;
  logic          done;
  modport master (
    output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    input  cmd_ready, pix_x, pix_y, pix_colour, pix_plot, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
    output cmd_ready, pix_x, pix_y, pix_colour, pix_plot, busy, done
  );
endinterface

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rasterises one clipped filled-rectangle command into a one-pixel-per-clock write stream
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : rect_fill_if.slave -- cmd_valid/ready/clear/x/y/w/h/colour in,
//           pix_x/y/colour/plot, busy, done out
module rect_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input logic       clk,
  input logic       reset,
  rect_fill_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
  localparam logic [XW:0] SW = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] SH = (YW+1)'(SCREEN_H);
  state_t        state, state_n;
  logic [XW-1:0] x0, w0, x_last, px;
  logic [YW-1:0] y0, h0, y_last, py;
  logic [CW-1:0] c0, pc;
  logic          plot, empty, last_pix;
  logic [XW:0]   x_end;
  logic [YW:0]   y_end;
  // one extra bit so x+w / y+h never wrap before clipping
  assign x_end    = {1'b0, x0} + {1'b0, w0};
  assign y_end    = {1'b0, y0} + {1'b0, h0};
  assign empty    = {1'b0, x0} >= SW || {1'b0, y0} >= SH || w0 == '0 || h0 == '0;
  assign last_pix = px == x_last && py == y_last;
  always_comb begin
    state_n = state == IDLE  ? (bus.cmd_valid ? SETUP : IDLE) :
              state == SETUP ? (empty ? DONE : FILL) :
              state == FILL  ? (last_pix ? DONE : FILL) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cmd_valid) begin
      x0 <= bus.cmd_clear ? '0 : bus.cmd_x;
      y0 <= bus.cmd_clear ? '0 : bus.cmd_y;
      w0 <= bus.cmd_clear ? XW'(SCREEN_W) : bus.cmd_w;
      h0 <= bus.cmd_clear ? YW'(SCREEN_H) : bus.cmd_h;
      c0 <= bus.cmd_clear ? '0 : bus.cmd_colour;
    end
    if (state == SETUP) begin
      x_last <= XW'((x_end > SW ? SW : x_end) - (XW+1)'(1));
      y_last <= YW'((y_end > SH ? SH : y_end) - (YW+1)'(1));
    end
  end
  // pixel registers: loaded with the top-left corner leaving SETUP, then stepped in raster order
  always_ff @(posedge clk) begin
    if (!reset) begin
      px   <= '0;
      py   <= '0;
      pc   <= '0;
      plot <= 1'b0;
    end else begin
      plot <= state_n == FILL;
      if (state == SETUP && !empty) begin
        px <= x0;
        py <= y0;
        pc <= c0;
      end else if (state == FILL && !last_pix) begin
        px <= px == x_last ? x0 : px + XW'(1);
        py <= px == x_last ? py + YW'(1) : py;
      end
    end
  end
  assign bus.cmd_ready  = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.done       = state == DONE;
  assign bus.pix_x      = px;
  assign bus.pix_y      = py;
  assign bus.pix_colour = pc;
  assign bus.pix_plot   = plot;
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: randomized and directed checks of rect_fill_engine against a clipped-rectangle pixel model
module tb_rect_fill_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  rect_fill_if bus();
  rect_fill_engine dut (.clk(clk), .reset(reset), .bus(bus));
  int errs = 0, checks = 0, cyc = 0, nobusy = 0;
  logic [17:0] exp_q[$], got_q[$];
  int plot_q[$], done_q[$], acc_q[$];
  // acc_q holds the index of the cycle in which valid&ready was presented
  always @(posedge clk) begin
    if (reset && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
    cyc++;
  end
  always @(negedge clk) begin
    if (bus.pix_plot) begin
      got_q.push_back({bus.pix_x, bus.pix_y, bus.pix_colour});
      plot_q.push_back(cyc);
      if (!bus.busy) nobusy++;
    end
    if (bus.done) done_q.push_back(cyc);
  end
  task automatic clr_q();
    exp_q.delete(); got_q.delete(); plot_q.delete(); done_q.delete(); acc_q.delete();
    nobusy = 0;
  endtask
  function automatic void model(bit clr, int x, int y, int w, int h, int c);
    if (clr) begin x = 0; y = 0; w = 160; h = 120; c = 0; end
    for (int j = y; j < y + h && j < 120; j++)
      for (int i = x; i < x + w && i < 160; i++)
        exp_q.push_back({8'(i), 7'(j), 3'(c)});
  endfunction
  function automatic int first_diff();
    int n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return got_q.size() == exp_q.size() ? -1 : n;
  endfunction
  task automatic drive(bit clr, int x, int y, int w, int h, int c);
    bus.cmd_clear = clr; bus.cmd_x = 8'(x); bus.cmd_y = 7'(y);
    bus.cmd_w = 8'(w); bus.cmd_h = 7'(h); bus.cmd_colour = 3'(c);
    bus.cmd_valid = 1'b1;
  endtask
  task automatic send(bit clr, int x, int y, int w, int h, int c);
    @(negedge clk);
    drive(clr, x, y, w, h, c);
    for (int i = 0; i < 30000 && !bus.cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_done(string name, int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    checks++; errs++;
    $display("FAIL %s_timeout: no done within %0d cycles", name, lim);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.pix_plot !== 1'b0) begin errs++; $display("FAIL reset_plot: got %b want 0", bus.pix_plot); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if ({bus.pix_x, bus.pix_y, bus.pix_colour} !== 18'd0) begin
      errs++; $display("FAIL reset_pix: got %h want 0", {bus.pix_x, bus.pix_y, bus.pix_colour}); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    reset = 1'b1;
  endtask
  task automatic test_square();
    int d;
    clr_q(); model(0, 10, 20, 4, 4, 5);
    send(0, 10, 20, 4, 4, 5);
    wait_done("square", 100);
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL square_ready: got %b want 1", bus.cmd_ready); end
    d = first_diff();
    checks++; if (d != -1 || got_q.size() != 16) begin
      errs++; $display("FAIL square_pixels: got %0d pixels, first diff %0d, want 16", got_q.size(), d); end
    checks++; if (acc_q.size() != 1 || plot_q.size() == 0 || plot_q[0] != acc_q[0] + 2) begin
      errs++; $display("FAIL square_first_plot: got cycle %0d want %0d", plot_q.size() ? plot_q[0] : -1, acc_q.size() ? acc_q[0] + 2 : -1); end
    checks++; if (done_q.size() != 1 || plot_q.size() == 0 || done_q[0] != plot_q[plot_q.size()-1] + 1) begin
      errs++; $display("FAIL square_done: got %0d done pulses, want 1 right after last plot", done_q.size()); end
    checks++; if (nobusy != 0) begin errs++; $display("FAIL square_busy: got %0d plots without busy want 0", nobusy); end
  endtask
  task automatic test_clip();
    int d;
    clr_q(); model(0, 158, 118, 4, 4, 2);
    send(0, 158, 118, 4, 4, 2);
    wait_done("clip", 100);
    @(negedge clk);
    d = first_diff();
    checks++; if (d != -1 || got_q.size() != 4) begin
      errs++; $display("FAIL clip_pixels: got %0d pixels, first diff %0d, want 4", got_q.size(), d); end
    clr_q(); model(0, 150, 100, 255, 127, 7);
    send(0, 150, 100, 255, 127, 7);
    wait_done("clip_wide", 400);
    @(negedge clk);
    d = first_diff();
    checks++; if (d != -1 || got_q.size() != 200) begin
      errs++; $display("FAIL clip_wide_pixels: got %0d pixels, first diff %0d, want 200", got_q.size(), d); end
  endtask
  task automatic test_clear();
    int d;
    clr_q(); model(1, 0, 0, 0, 0, 0);
    send(1, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(0, 127), 7);
    wait_done("clear", 20100);
    @(negedge clk);
    d = first_diff();
    checks++; if (d != -1 || got_q.size() != 19200) begin
      errs++; $display("FAIL clear_pixels: got %0d pixels, first diff %0d, want 19200", got_q.size(), d); end
    checks++; if (plot_q.size() == 0 || plot_q[plot_q.size()-1] - plot_q[0] != 19199) begin
      errs++; $display("FAIL clear_contiguous: got span %0d want 19199", plot_q.size() ? plot_q[plot_q.size()-1] - plot_q[0] : -1); end
    checks++; if (nobusy != 0) begin errs++; $display("FAIL clear_busy: got %0d plots without busy want 0", nobusy); end
  endtask
  task automatic test_empty();
    int cmds[2][4] = '{'{5, 5, 0, 3}, '{200, 5, 5, 5}};
    foreach (cmds[k]) begin
      clr_q();
      send(0, cmds[k][0], cmds[k][1], cmds[k][2], cmds[k][3], 4);
      wait_done("empty", 20);
      @(negedge clk);
      checks++; if (got_q.size() != 0) begin errs++; $display("FAIL empty_plots: got %0d want 0", got_q.size()); end
      checks++; if (acc_q.size() != 1 || done_q.size() != 1 || done_q[0] != acc_q[0] + 2) begin
        errs++; $display("FAIL empty_done: got %0d pulses at %0d want 1 at accept+2", done_q.size(), done_q.size() ? done_q[0] - (acc_q.size() ? acc_q[0] : 0) : -1); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL empty_ready: got %b want 1", bus.cmd_ready); end
    end
  endtask
  task automatic test_random();
    int x, y, w, h, c, d;
    for (int k = 0; k < 8; k++) begin
      x = $urandom_range(0, 170); y = $urandom_range(0, 127);
      w = $urandom_range(0, 255); h = $urandom_range(0, 20); c = $urandom_range(0, 7);
      clr_q(); model(0, x, y, w, h, c);
      send(0, x, y, w, h, c);
      wait_done("random", 5000);
      @(negedge clk);
      d = first_diff();
      checks++; if (d != -1) begin
        errs++; $display("FAIL random_pixels: cmd (%0d,%0d,%0d,%0d) got %0d pixels, first diff %0d, want %0d", x, y, w, h, got_q.size(), d, exp_q.size()); end
      checks++; if (acc_q.size() != 1 || done_q.size() != 1 || done_q[0] != acc_q[0] + exp_q.size() + 2) begin
        errs++; $display("FAIL random_done: got %0d pulses, want 1 at accept+%0d", done_q.size(), exp_q.size() + 2); end
    end
  endtask
  task automatic test_reset_mid();
    int n = 0, rel, d;
    clr_q(); model(0, 10, 20, 4, 4, 5);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    model(0, 20, 30, 2, 2, 6);
    send(0, 10, 20, 4, 4, 5);
    for (int i = 0; i < 50 && n < 5; i++) begin
      @(negedge clk);
      if (bus.pix_plot) n++;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({bus.pix_plot, bus.busy, bus.done} !== 3'b000) begin
      errs++; $display("FAIL midreset_outputs: got plot/busy/done %b want 000", {bus.pix_plot, bus.busy, bus.done}); end
    @(negedge clk);
    rel = cyc;
    reset = 1'b1;
    drive(0, 20, 30, 2, 2, 6);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_done("midreset", 50);
    @(negedge clk);
    checks++; if (acc_q.size() != 2 || acc_q[1] != rel) begin
      errs++; $display("FAIL midreset_accept: got %0d accepts, want 2 with second at %0d", acc_q.size(), rel); end
    d = first_diff();
    checks++; if (d != -1) begin
      errs++; $display("FAIL midreset_pixels: got %0d pixels, first diff %0d, want %0d", got_q.size(), d, exp_q.size()); end
  endtask
  task automatic test_back_to_back();
    int d;
    clr_q(); model(0, 10, 20, 4, 4, 5); model(0, 30, 40, 3, 2, 2);
    @(negedge clk);
    drive(0, 10, 20, 4, 4, 5);
    @(posedge clk);
    #1 drive(0, 30, 40, 3, 2, 2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_done("b2b", 50);
    @(negedge clk);
    checks++; if (acc_q.size() != 2 || done_q.size() != 2 || acc_q[1] != done_q[0] + 1) begin
      errs++; $display("FAIL b2b_accept: got %0d accepts / %0d dones, want 2 with second accept right after first done", acc_q.size(), done_q.size()); end
    d = first_diff();
    checks++; if (d != -1 || got_q.size() != 22) begin
      errs++; $display("FAIL b2b_pixels: got %0d pixels, first diff %0d, want 22", got_q.size(), d); end
    checks++; if (done_q.size() != 2 || acc_q.size() != 2 || done_q[1] != acc_q[1] + 8) begin
      errs++; $display("FAIL b2b_done: got %0d dones, want second at accept+8", done_q.size()); end
  endtask
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_clear = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_colour = '0;
    test_reset();
    test_square();
    test_clip();
    test_clear();
    test_empty();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
